// File: rtl/corescore_pkg.sv
// -----------------------------------------------------------------------------
// corescore_pkg
// Shared definitions for the corescore stream arbiter slice.
//   BYTE_W       : width of one stream beat (the UART emitter is byte wide)
//   arb_state_t  : arbiter FSM encoding, IDLE (no owner) and XFER (packet open)
//   idxWidth()   : width needed to hold a source index, never less than one bit
// -----------------------------------------------------------------------------
package corescore_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } arb_state_t;

   // A single-source build still needs a one-bit index register.
   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/corescore_rr_pick.sv
// -----------------------------------------------------------------------------
// corescore_rr_pick
// Combinational rotating-priority picker. The search starts one place after
// the previous winner and wraps, so the previous winner has lowest priority.
// Ports:
//   i_req  [NUM_SRC] : request vector (one bit per source)
//   i_last [IDX_W]   : index of the previous winner
//   o_pick [NUM_SRC] : one-hot winner, all zeros when nothing is requesting
//   o_idx  [IDX_W]   : binary index of the winner, zero when nothing requests
// -----------------------------------------------------------------------------
module corescore_rr_pick #(
   parameter int NUM_SRC = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_SRC-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last,
   output logic [NUM_SRC-1:0] o_pick,
   output logic [IDX_W-1:0]   o_idx
);

   int               w_cand;
   logic [IDX_W-1:0] w_candIdx;
   logic             w_found;

   // Walk the sources in priority order starting just after the last winner.
   // The first requester found wins; later hits are ignored via w_found.
   always_comb begin
      o_pick    = '0;
      o_idx     = '0;
      w_found   = 1'b0;
      w_cand    = 0;
      w_candIdx = '0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         w_cand    = (int'(i_last) + i) % NUM_SRC;
         w_candIdx = IDX_W'(w_cand);
         if (!w_found && i_req[w_candIdx]) begin
            w_found           = 1'b1;
            o_pick[w_candIdx] = 1'b1;
            o_idx             = w_candIdx;
         end
      end
   end

endmodule

// File: rtl/corescore_stream_arbiter.sv
// -----------------------------------------------------------------------------
// corescore_stream_arbiter
// Packet-granular round-robin arbiter sharing one byte-wide AXI-Stream sink
// between NUM_SRC sources. A source owns the sink from grant until its tlast
// beat is accepted; packets never interleave. Counts forwarded packets.
// Ports:
//   i_clk, i_rst_n         : clock and synchronous active-low reset
//   i_tdata/i_tlast/i_tvalid : source streams, source k at byte lane k
//   o_tready [NUM_SRC]     : per-source ready, only the owner's bit can be 1
//   o_tdata/o_tlast/o_tvalid, i_tready : sink stream
//   o_grant [NUM_SRC]      : one-hot owner, zero when idle
//   o_busy                 : a packet is in progress
//   o_pkt_cnt [PKT_CNT_W]  : wrapping count of completed packets
// -----------------------------------------------------------------------------
module corescore_stream_arbiter
   import corescore_pkg::*;
#(
   parameter int NUM_SRC   = 4,
   parameter int PKT_CNT_W = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [NUM_SRC*BYTE_W-1:0]   i_tdata,
   input  logic [NUM_SRC-1:0]          i_tlast,
   input  logic [NUM_SRC-1:0]          i_tvalid,
   output logic [NUM_SRC-1:0]          o_tready,
   output logic [BYTE_W-1:0]           o_tdata,
   output logic                        o_tlast,
   output logic                        o_tvalid,
   input  logic                        i_tready,
   output logic [NUM_SRC-1:0]          o_grant,
   output logic                        o_busy,
   output logic [PKT_CNT_W-1:0]        o_pkt_cnt
);

   localparam int IDX_W = idxWidth(NUM_SRC);

   arb_state_t           r_state;
   arb_state_t           w_nextState;
   logic [NUM_SRC-1:0]   r_grant;
   logic [IDX_W-1:0]     r_lastWinner;
   logic [PKT_CNT_W-1:0] r_pktCnt;
   logic [NUM_SRC-1:0]   w_pick;
   logic [IDX_W-1:0]     w_pickIdx;
   logic                 w_pktDone;
   logic [BYTE_W-1:0]    w_srcData [NUM_SRC];

   corescore_rr_pick #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_pick (
      .i_req  (i_tvalid),
      .i_last (r_lastWinner),
      .o_pick (w_pick),
      .o_idx  (w_pickIdx)
   );

   // Split the flat data bus into per-source byte lanes for the mux below.
   always_comb begin
      for (int k = 0; k < NUM_SRC; k++) begin
         w_srcData[k] = i_tdata[k*BYTE_W +: BYTE_W];
      end
   end

   // Next-state and sink datapath. While a packet is open the last winner is
   // also the current owner, so it doubles as the mux select and no separate
   // owner index register is needed. Sink outputs are forced to zero in IDLE.
   always_comb begin
      w_nextState = r_state;
      w_pktDone   = 1'b0;
      o_tdata     = '0;
      o_tlast     = 1'b0;
      o_tvalid    = 1'b0;
      o_tready    = '0;
      case (r_state)
         ST_IDLE: begin
            if (|i_tvalid) begin
               w_nextState = ST_XFER;
            end
         end
         ST_XFER: begin
            o_tdata  = w_srcData[r_lastWinner];
            o_tlast  = i_tlast[r_lastWinner];
            o_tvalid = i_tvalid[r_lastWinner];
            o_tready = r_grant & {NUM_SRC{i_tready}};
            if (i_tvalid[r_lastWinner] && i_tready && i_tlast[r_lastWinner]) begin
               w_pktDone   = 1'b1;
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // State, grant, last winner and packet counter. The grant is captured from
   // the picker only in IDLE, so requests arriving mid-packet simply wait for
   // the next IDLE cycle. Reset leaves the last winner at the top index so
   // source 0 is searched first.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_lastWinner <= IDX_W'(NUM_SRC - 1);
         r_pktCnt     <= '0;
      end else begin
         r_state <= w_nextState;
         if (r_state == ST_IDLE && |i_tvalid) begin
            r_grant      <= w_pick;
            r_lastWinner <= w_pickIdx;
         end else if (w_pktDone) begin
            r_grant  <= '0;
            r_pktCnt <= r_pktCnt + PKT_CNT_W'(1);
         end
      end
   end

   assign o_grant   = r_grant;
   assign o_busy    = (r_state == ST_XFER);
   assign o_pkt_cnt = r_pktCnt;

endmodule
